// File: rtl/cap_sense_pkg.sv
// ============================================================
// cap_sense_pkg: shared widths, FSM state encoding and
// calibration constants for the capacitive pad scanner.
// Revision: 1.0
// ============================================================
`default_nettype none

package cap_sense_pkg;

  localparam int c_num_sensors = 9;
  localparam int c_cnt_w       = 16;
  localparam int c_calib_scans = 8;
  localparam int c_calib_shift = $clog2(c_calib_scans);

  localparam int c_state_w = 2;
  typedef logic [c_state_w-1:0] state_t;

  localparam logic [1:0] c_st_idle      = 2'd0;
  localparam logic [1:0] c_st_discharge = 2'd1;
  localparam logic [1:0] c_st_charge    = 2'd2;
  localparam logic [1:0] c_st_eval      = 2'd3;

endpackage

`default_nettype wire

// File: rtl/cap_sense_channel.sv
// ============================================================
// cap_sense_channel: one pad - synchronizer, first-high latch,
// threshold compare, debounce and sticky touch event.
// Optional: CAP_SENSE_CALIB_EN adds a baseline accumulator.
// Revision: 1.0
// ============================================================
`default_nettype none

module cap_sense_channel
  import cap_sense_pkg::*;
#(
  parameter int CNT_W     = c_cnt_w,
  parameter int TIMEOUT   = 4095,
  parameter int THRESHOLD = 200,
  parameter int DEBOUNCE  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pad_in,
  input  logic             clear,
  input  logic             charge,
  input  logic             eval,
  input  logic             calib_done,
  input  logic             event_ack,
  input  logic [CNT_W-1:0] count,
  output logic             latched_next,
  output logic             touch,
  output logic             touch_event,
  output logic             fault
);

  localparam int c_deb_w = $clog2(DEBOUNCE + 1);
  localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEBOUNCE - 1);

  logic [1:0]         r_sync;
  logic               r_latched;
  logic [CNT_W-1:0]   r_lat_cnt;
  logic [c_deb_w-1:0] r_deb;
  logic               r_touch;
  logic               r_fault;
  logic               r_rise;
  logic               r_event;
  logic [CNT_W:0]     w_limit;
  logic               w_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], pad_in};
    end
  end

`ifdef CAP_SENSE_CALIB_EN
  logic [CNT_W+2:0] r_sum;
  logic [CNT_W-1:0] w_baseline;

  // Unlatched channels contribute the full timeout so a dead pad raises its own limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
    end else if (eval && !calib_done) begin
      r_sum <= r_sum + (CNT_W+3)'(r_latched ? r_lat_cnt : CNT_W'(TIMEOUT));
    end
  end

  assign w_baseline = CNT_W'(r_sum >> c_calib_shift);
  assign w_limit    = {1'b0, w_baseline} + (CNT_W+1)'(THRESHOLD);
`else
  assign w_limit = (CNT_W+1)'(THRESHOLD);
`endif

  assign w_raw = calib_done & r_latched & ({1'b0, r_lat_cnt} > w_limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_latched <= 1'b0;
      r_lat_cnt <= '0;
      r_deb     <= '0;
      r_touch   <= 1'b0;
      r_fault   <= 1'b0;
      r_rise    <= 1'b0;
      r_event   <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      if (clear) begin
        r_latched <= 1'b0;
        r_lat_cnt <= '0;
      end else if (charge && !r_latched && r_sync[1]) begin
        r_latched <= 1'b1;
        r_lat_cnt <= count;
      end
      if (eval) begin
        r_fault <= ~r_latched;
        if (w_raw != r_touch) begin
          if (r_deb == c_deb_last) begin
            r_touch <= w_raw;
            r_deb   <= '0;
            r_rise  <= w_raw;
          end else begin
            r_deb <= r_deb + c_deb_w'(1);
          end
        end else begin
          r_deb <= '0;
        end
      end
      // A new rise outranks a simultaneous acknowledge.
      r_event <= (r_event & ~event_ack) | r_rise;
    end
  end

  assign latched_next = r_latched | (charge & r_sync[1]);
  assign touch        = r_touch;
  assign touch_event  = r_event;
  assign fault        = r_fault;

endmodule

`default_nettype wire

// File: rtl/cap_sense_scanner.sv
// ============================================================
// cap_sense_scanner: scan FSM, shared charge counter and drive
// line for NUM_SENSORS capacitive pads.
// Optional: CAP_SENSE_CALIB_EN enables baseline calibration.
// Revision: 1.0
// ============================================================
`default_nettype none

module cap_sense_scanner
  import cap_sense_pkg::*;
#(
  parameter int NUM_SENSORS      = c_num_sensors,
  parameter int CNT_W            = c_cnt_w,
  parameter int DISCHARGE_CYCLES = 1024,
  parameter int TIMEOUT          = 4095,
  parameter int THRESHOLD        = 200,
  parameter int DEBOUNCE         = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   scan_en,
  input  logic [NUM_SENSORS-1:0] capacitive_sensors_in,
  output logic                   capacitive_sensors_out,
  output logic [NUM_SENSORS-1:0] touch_bitmap,
  output logic [NUM_SENSORS-1:0] touch_events,
  input  logic [NUM_SENSORS-1:0] event_ack,
  output logic [NUM_SENSORS-1:0] fault_bitmap,
  output logic                   scan_done,
  output logic                   busy,
  output logic                   calib_done
);

  localparam int c_dis_w = $clog2(DISCHARGE_CYCLES + 1);
  localparam logic [c_dis_w-1:0] c_dis_last = c_dis_w'(DISCHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   c_timeout  = CNT_W'(TIMEOUT);

  state_t                 r_state;
  logic [c_dis_w-1:0]     r_dis_cnt;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_scan_done;
  logic [NUM_SENSORS-1:0] w_latched_next;
  logic                   w_all_latched;
  logic                   w_calib_done;
  logic                   w_charge;
  logic                   w_eval;
  logic                   w_clear;

  assign w_charge      = (r_state == c_st_charge);
  assign w_eval        = (r_state == c_st_eval);
  assign w_clear       = (r_state == c_st_discharge);
  assign w_all_latched = &w_latched_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= c_st_idle;
      r_dis_cnt   <= '0;
      r_cnt       <= '0;
      r_scan_done <= 1'b0;
    end else begin
      r_scan_done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (scan_en) begin
            r_state   <= c_st_discharge;
            r_dis_cnt <= '0;
          end
        end
        c_st_discharge: begin
          if (r_dis_cnt == c_dis_last) begin
            r_state <= c_st_charge;
            r_cnt   <= '0;
          end else begin
            r_dis_cnt <= r_dis_cnt + c_dis_w'(1);
          end
        end
        // Exit counts channels latching this very cycle, so the last rise ends CHARGE.
        c_st_charge: begin
          if (w_all_latched || (r_cnt == c_timeout)) begin
            r_state <= c_st_eval;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        c_st_eval: begin
          r_scan_done <= 1'b1;
          r_dis_cnt   <= '0;
          r_state     <= scan_en ? c_st_discharge : c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

`ifdef CAP_SENSE_CALIB_EN
  logic [3:0] r_calib_cnt;
  logic       r_calib_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_calib_cnt  <= '0;
      r_calib_done <= 1'b0;
    end else if (w_eval && !r_calib_done) begin
      r_calib_cnt <= r_calib_cnt + 4'd1;
      if (r_calib_cnt == 4'(c_calib_scans - 1)) begin
        r_calib_done <= 1'b1;
      end
    end
  end

  assign w_calib_done = r_calib_done;
`else
  assign w_calib_done = 1'b1;
`endif

  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_ch
    cap_sense_channel #(
      .CNT_W     (CNT_W),
      .TIMEOUT   (TIMEOUT),
      .THRESHOLD (THRESHOLD),
      .DEBOUNCE  (DEBOUNCE)
    ) u_channel (
      .clk          (clock),
      .rst          (reset),
      .pad_in       (capacitive_sensors_in[g]),
      .clear        (w_clear),
      .charge       (w_charge),
      .eval         (w_eval),
      .calib_done   (w_calib_done),
      .event_ack    (event_ack[g]),
      .count        (r_cnt),
      .latched_next (w_latched_next[g]),
      .touch        (touch_bitmap[g]),
      .touch_event  (touch_events[g]),
      .fault        (fault_bitmap[g])
    );
  end

  assign capacitive_sensors_out = w_charge;
  assign scan_done              = r_scan_done;
  assign busy                   = (r_state != c_st_idle);
  assign calib_done             = w_calib_done;

endmodule

`default_nettype wire

// File: tb/tb_cap_sense_scanner.sv
// ============================================================
// tb_cap_sense_scanner: scan-level reference model bench for
// cap_sense_scanner (CAP_SENSE_CALIB_EN selects calibration).
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_cap_sense_scanner;

  localparam int NS    = 9;
  localparam int DIS   = 4;
  localparam int TO    = 100;
  localparam int TH    = 20;
  localparam int DB    = 2;
  localparam int NEVER = 1000;
`ifdef CAP_SENSE_CALIB_EN
  localparam bit CAL_EN = 1'b1;
`else
  localparam bit CAL_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          scan_en;
  logic [NS-1:0] pads;
  logic [NS-1:0] ack;
  logic          drive;
  logic [NS-1:0] bm;
  logic [NS-1:0] evt;
  logic [NS-1:0] flt;
  logic          sdone;
  logic          busy;
  logic          cdone;

  always #5 clock = ~clock;

  cap_sense_scanner #(
    .NUM_SENSORS      (NS),
    .CNT_W            (16),
    .DISCHARGE_CYCLES (DIS),
    .TIMEOUT          (TO),
    .THRESHOLD        (TH),
    .DEBOUNCE         (DB)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .scan_en                (scan_en),
    .capacitive_sensors_in  (pads),
    .capacitive_sensors_out (drive),
    .touch_bitmap           (bm),
    .touch_events           (evt),
    .event_ack              (ack),
    .fault_bitmap           (flt),
    .scan_done              (sdone),
    .busy                   (busy),
    .calib_done             (cdone)
  );

  int checks   = 0;
  int failures = 0;

  // Stimulus: charge-count at which each pad is driven high (NEVER = stays low).
  int rise_at [NS];

  // Reference model state, one step per scan.
  logic [NS-1:0] m_bm;
  logic [NS-1:0] m_evt;
  int            m_deb  [NS];
  int            m_sum  [NS];
  int            m_base [NS];
  int            m_scans;
  bit            m_cal;

  task automatic model_reset();
    m_bm    = '0;
    m_evt   = '0;
    m_scans = 0;
    m_cal   = !CAL_EN;
    for (int i = 0; i < NS; i++) begin
      m_deb[i]  = 0;
      m_sum[i]  = 0;
      m_base[i] = 0;
    end
  endtask

  task automatic set_all(input int k);
    for (int i = 0; i < NS; i++) rise_at[i] = k;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (drive !== 1'b0 || busy !== 1'b0 || bm !== '0 || evt !== '0 || flt !== '0 ||
        sdone !== 1'b0 || cdone !== !CAL_EN) begin
      failures++;
      $display("FAIL %s: drive=%b busy=%b bm=%h evt=%h flt=%h done=%b calib=%b, want all 0 calib=%b",
               tag, drive, busy, bm, evt, flt, sdone, cdone, !CAL_EN);
    end
  endtask

  // Runs one full scan with the current rise_at[] and checks it against the model.
  task automatic run_scan(input logic [NS-1:0] ack_mask, input bit ack_early, output int low_cycles);
    int            lat [NS];
    int            maxl;
    int            exp_n;
    int            n;
    int            guard;
    bit            all;
    logic [NS-1:0] raw;
    logic [NS-1:0] exp_flt;
    logic [NS-1:0] rises;

    // A pad driven high during count k is first seen two cycles later.
    all  = 1'b1;
    maxl = 0;
    for (int i = 0; i < NS; i++) begin
      if (rise_at[i] + 2 <= TO) begin
        lat[i] = rise_at[i] + 2;
        if (lat[i] > maxl) maxl = lat[i];
      end else begin
        lat[i] = -1;
        all    = 1'b0;
      end
    end
    exp_n = all ? maxl + 1 : TO + 1;

    rises = '0;
    for (int i = 0; i < NS; i++) begin
      exp_flt[i] = (lat[i] < 0);
      raw[i]     = m_cal && (lat[i] >= 0) && (lat[i] > m_base[i] + TH);
      if (raw[i] != m_bm[i]) begin
        m_deb[i]++;
        if (m_deb[i] >= DB) begin
          m_bm[i]  = raw[i];
          m_deb[i] = 0;
          if (raw[i]) rises[i] = 1'b1;
        end
      end else begin
        m_deb[i] = 0;
      end
    end
    if (CAL_EN && !m_cal) begin
      for (int i = 0; i < NS; i++) m_sum[i] += (lat[i] >= 0) ? lat[i] : TO;
      m_scans++;
      if (m_scans == 8) begin
        m_cal = 1'b1;
        for (int i = 0; i < NS; i++) m_base[i] = m_sum[i] >> 3;
      end
    end

    low_cycles = 0;
    guard      = 0;
    do begin
      @(negedge clock);
      if (drive === 1'b0) low_cycles++;
      guard++;
    end while (drive !== 1'b1 && guard < 300);
    if (drive !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL charge_start: drive never rose within %0d cycles", guard);
      return;
    end

    n = 0;
    while (drive === 1'b1 && n <= TO + 5) begin
      for (int i = 0; i < NS; i++) if (rise_at[i] == n) pads[i] = 1'b1;
      n++;
      @(negedge clock);
    end
    pads = '0;

    checks++;
    if (n != exp_n) begin
      failures++;
      $display("FAIL charge_len: got %0d cycles, want %0d", n, exp_n);
    end

    @(negedge clock);
    checks++;
    if (sdone !== 1'b1 || bm !== m_bm || flt !== exp_flt || cdone !== m_cal) begin
      failures++;
      $display("FAIL scan_result: done=%b bm=%h flt=%h calib=%b, want done=1 bm=%h flt=%h calib=%b",
               sdone, bm, flt, cdone, m_bm, exp_flt, m_cal);
    end
    if (ack_early) ack = ack_mask;

    @(negedge clock);
    ack = '0;
    if (ack_early) m_evt = m_evt & ~ack_mask;
    m_evt = m_evt | rises;
    checks++;
    if (sdone !== 1'b0 || evt !== m_evt) begin
      failures++;
      $display("FAIL events: done=%b evt=%h, want done=0 evt=%h", sdone, evt, m_evt);
    end

    if (!ack_early && ack_mask != '0) begin
      ack = ack_mask;
      @(negedge clock);
      ack   = '0;
      m_evt = m_evt & ~ack_mask;
      checks++;
      if (evt !== m_evt) begin
        failures++;
        $display("FAIL event_ack: evt=%h, want %h", evt, m_evt);
      end
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    scan_en = 1'b1;
    pads    = '0;
    ack     = '0;
    model_reset();
    set_all(NEVER);
    #1;
    check_reset_outputs("reset_state");
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_first_scan();
    int low;
    set_all(3);
    run_scan('0, 1'b0, low);
    checks++;
    if (low != DIS) begin
      failures++;
      $display("FAIL discharge_len: got %0d low cycles, want %0d", low, DIS);
    end
  endtask

  task automatic test_threshold();
    int low;
    set_all(3);
    rise_at[3] = 40;
    run_scan('0, 1'b0, low);
    run_scan(9'h008, 1'b0, low);
  endtask

  task automatic test_timeout();
    int low;
    set_all(3);
    rise_at[3] = 40;
    rise_at[0] = NEVER;
    run_scan('0, 1'b0, low);
    rise_at[0] = 98;
    run_scan('0, 1'b0, low);
  endtask

  task automatic test_debounce_ack();
    int low;
    set_all(3);
    rise_at[3] = 40;
    for (int s = 0; s < 4; s++) begin
      rise_at[5] = (s % 2 == 0) ? 40 : 3;
      run_scan('0, 1'b0, low);
    end
    rise_at[5] = 3;
    rise_at[7] = 40;
    run_scan('0, 1'b0, low);
    run_scan(9'h080, 1'b1, low);
  endtask

  task automatic test_stop();
    int low;
    set_all(3);
    rise_at[3] = 40;
    scan_en = 1'b0;
    run_scan('0, 1'b0, low);
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || drive !== 1'b0) begin
      failures++;
      $display("FAIL stop_idle: busy=%b drive=%b, want 0 0", busy, drive);
    end
    scan_en = 1'b1;
  endtask

  task automatic test_mid_reset();
    int low;
    int guard;
    set_all(60);
    guard = 0;
    do begin
      @(negedge clock);
      guard++;
    end while (drive !== 1'b1 && guard < 300);
    repeat (3) @(negedge clock);
    pads  = '0;
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_charge_reset");
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    set_all(3);
    run_scan('0, 1'b0, low);
    checks++;
    if (low != DIS) begin
      failures++;
      $display("FAIL restart_discharge: got %0d low cycles, want %0d", low, DIS);
    end
  endtask

  task automatic test_random();
    int            low;
    int            mode [NS];
    logic [NS-1:0] mask;
    for (int i = 0; i < NS; i++) mode[i] = $urandom_range(0, 2);
    for (int s = 0; s < 24; s++) begin
      for (int i = 0; i < NS; i++) begin
        if ($urandom_range(0, 3) == 0) mode[i] = $urandom_range(0, 2);
        case (mode[i])
          0:       rise_at[i] = $urandom_range(0, 15);
          1:       rise_at[i] = $urandom_range(25, 98);
          default: rise_at[i] = ($urandom_range(0, 3) == 0) ? NEVER : $urandom_range(40, 98);
        endcase
      end
      mask = NS'($urandom_range(0, (1 << NS) - 1));
      if ($urandom_range(0, 1) == 0) mask = '0;
      run_scan(mask, 1'($urandom_range(0, 1)), low);
    end
  endtask

  task automatic test_calib();
    int low;
    @(negedge clock);
    pads  = '0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    set_all(48);
    for (int s = 0; s < 8; s++) run_scan('0, 1'b0, low);
    rise_at[2] = 73;
    run_scan('0, 1'b0, low);
    run_scan('0, 1'b0, low);
    rise_at[2] = 63;
    run_scan('0, 1'b0, low);
    run_scan('0, 1'b0, low);
  endtask

  initial begin
    test_reset();
    test_first_scan();
    test_threshold();
    test_timeout();
    test_debounce_ack();
    test_stop();
    test_mid_reset();
    test_random();
    if (CAL_EN) test_calib();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
